// File: rtl/button_event_ctrl.sv
// button_event_ctrl
//   Turns N debounced button levels into a serial stream of PRESS / RELEASE /
//   LONG / REPEAT events. Each button has its own FSM, a hold counter and a
//   single-entry pending slot. A round-robin arbiter moves the pending events
//   into one registered output with a valid/ready handshake.
//
// Ports
//   ck        clock, rising edge
//   reset     asynchronous, active-low reset
//   db        debounced, synchronous button levels (1 = pressed)
//   ev_ready  consumer accepts the event this cycle
//   clr_ovf   synchronous clear of the sticky ovf flag
//   ev_valid  event present on ev_id / ev_code
//   ev_id     originating button index
//   ev_code   0 PRESS, 1 RELEASE, 2 LONG, 3 REPEAT
//   ovf       sticky: a pending event was overwritten before it was granted
module button_event_ctrl #(
  parameter int N       = 4,
  parameter int CNT_W   = 24,
  parameter int LONG_TH = 12_500_000,
  parameter int REP_TH  = 2_500_000
) (
  input  logic                 ck,
  input  logic                 reset,
  input  logic [N-1:0]         db,
  input  logic                 ev_ready,
  input  logic                 clr_ovf,
  output logic                 ev_valid,
  output logic [$clog2(N)-1:0] ev_id,
  output logic [1:0]           ev_code,
  output logic                 ovf
);

  localparam int ID_W = $clog2(N);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TH - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_TH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HELD = 2'd1,
    S_LONG = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    EV_PRESS   = 2'd0,
    EV_RELEASE = 2'd1,
    EV_LONG    = 2'd2,
    EV_REPEAT  = 2'd3
  } code_t;

  state_t           state     [N];
  logic [CNT_W-1:0] cnt       [N];
  logic [N-1:0]     slot_v;
  code_t            slot_c    [N];
  logic [ID_W-1:0]  last_grant;

  logic [N-1:0]     post;
  code_t            post_code [N];
  logic [N-1:0]     ovw;
  logic             free;
  logic             gnt_hit;
  logic             gnt_take;
  logic [ID_W-1:0]  gnt_idx;

  // Index of the k-th slot after base, wrapping at N (N need not be a power of 2).
  function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base,
                                             input int unsigned     k);
    int unsigned s;
    s = 32'(base);
    s = s + k;
    return ID_W'(s % N);
  endfunction

  // Event each button posts this cycle; release beats LONG/REPEAT.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      post[i]      = 1'b0;
      post_code[i] = EV_PRESS;
      case (state[i])
        S_IDLE: begin
          if (db[i]) begin
            post[i]      = 1'b1;
            post_code[i] = EV_PRESS;
          end
        end
        S_HELD: begin
          if (!db[i]) begin
            post[i]      = 1'b1;
            post_code[i] = EV_RELEASE;
          end else if (cnt[i] == LONG_LAST) begin
            post[i]      = 1'b1;
            post_code[i] = EV_LONG;
          end
        end
        S_LONG: begin
          if (!db[i]) begin
            post[i]      = 1'b1;
            post_code[i] = EV_RELEASE;
          end else if (cnt[i] == REP_LAST) begin
            post[i]      = 1'b1;
            post_code[i] = EV_REPEAT;
          end
        end
        default: ;
      endcase
    end
  end

  // Round-robin search starting one past the last granted slot.
  always_comb begin
    free    = !ev_valid || ev_ready;
    gnt_hit = 1'b0;
    gnt_idx = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      if (!gnt_hit && slot_v[rr_idx(last_grant, k)]) begin
        gnt_hit = 1'b1;
        gnt_idx = rr_idx(last_grant, k);
      end
    end
    gnt_take = free && gnt_hit;
  end

  // A post only counts as an overwrite if the slot is not emptied at this edge.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      ovw[i] = post[i] && slot_v[i] && !(gnt_take && gnt_idx == ID_W'(i));
    end
  end

  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < N; i++) begin
        state[i]  <= S_IDLE;
        cnt[i]    <= '0;
        slot_c[i] <= EV_PRESS;
      end
      slot_v     <= '0;
      last_grant <= ID_W'(N - 1);
      ev_valid   <= 1'b0;
      ev_id      <= '0;
      ev_code    <= '0;
      ovf        <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        case (state[i])
          S_IDLE: begin
            if (db[i]) begin
              state[i] <= S_HELD;
              cnt[i]   <= '0;
            end
          end
          S_HELD: begin
            if (!db[i]) begin
              state[i] <= S_IDLE;
            end else if (cnt[i] == LONG_LAST) begin
              state[i] <= S_LONG;
              cnt[i]   <= '0;
            end else begin
              cnt[i] <= cnt[i] + CNT_ONE;
            end
          end
          S_LONG: begin
            if (!db[i]) begin
              state[i] <= S_IDLE;
            end else if (cnt[i] == REP_LAST) begin
              cnt[i] <= '0;
            end else begin
              cnt[i] <= cnt[i] + CNT_ONE;
            end
          end
          default: state[i] <= S_IDLE;
        endcase

        // A new post wins over the grant clearing the same slot.
        if (post[i]) begin
          slot_v[i] <= 1'b1;
          slot_c[i] <= post_code[i];
        end else if (gnt_take && gnt_idx == ID_W'(i)) begin
          slot_v[i] <= 1'b0;
        end
      end

      if (free) begin
        if (gnt_hit) begin
          ev_valid   <= 1'b1;
          ev_id      <= gnt_idx;
          ev_code    <= slot_c[gnt_idx];
          last_grant <= gnt_idx;
        end else begin
          ev_valid <= 1'b0;
        end
      end

      if (|ovw) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule
